// File: rtl/spi_reg_sequencer.sv
// Register-programming sequencer: shifts NUM_WORDS LE-framed words out LSB first over SPI,
// optionally capturing MISO for read-flagged words.
module spi_reg_sequencer #(
  parameter int NUM_WORDS  = 6,
  parameter int WORD_WIDTH = 32,
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 8,
  parameter int IDX_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [NUM_WORDS*WORD_WIDTH-1:0] words,
  input  logic [NUM_WORDS-1:0]            read_mask,
  output logic                            busy,
  output logic                            done,
  output logic [WORD_WIDTH-1:0]           rd_data,
  output logic                            rd_valid,
  output logic [IDX_W-1:0]                rd_index,
  output logic                            spi_clk,
  output logic                            spi_le,
  output logic                            spi_mosi,
  input  logic                            spi_miso
);

  localparam int CntMax = (2 * CLK_DIV > GAP_CYCLES) ? 2 * CLK_DIV : GAP_CYCLES;
  localparam int CntW   = $clog2(CntMax);
  localparam int BitW   = $clog2(WORD_WIDTH);

  localparam logic [CntW-1:0]  HalfLast   = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0]  PeriodLast = CntW'(2 * CLK_DIV - 1);
  localparam logic [CntW-1:0]  GapLast    = CntW'(GAP_CYCLES - 1);
  localparam logic [BitW-1:0]  BitLast    = BitW'(WORD_WIDTH - 1);
  localparam logic [IDX_W-1:0] WordLast   = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [IDX_W-1:0]      idx_q, idx_d, next_idx;
  logic [WORD_WIDTH-1:0] sh_q, sh_d;
  logic [WORD_WIDTH-1:0] rx_q, rx_d;
  logic                  rd_en_q, rd_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [WORD_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [IDX_W-1:0]      rd_index_q, rd_index_d;
  logic                  sclk_q, sclk_d;
  logic                  le_q, le_d;
  logic                  mosi_q, mosi_d;

  logic [WORD_WIDTH-1:0] word_arr [NUM_WORDS];

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_words
    assign word_arr[k] = words[k*WORD_WIDTH +: WORD_WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    idx_d      = idx_q;
    sh_d       = sh_q;
    rx_d       = rx_q;
    rd_en_d    = rd_en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_index_d = rd_index_q;
    sclk_d     = sclk_q;
    le_d       = le_q;
    mosi_d     = mosi_q;
    next_idx   = idx_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSetup;
          cnt_d   = '0;
          idx_d   = '0;
          sh_d    = word_arr[0];
          mosi_d  = word_arr[0][0];
          rd_en_d = read_mask[0];
          le_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      StSetup: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HalfLast) begin
          state_d = StShift;
          cnt_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b1;
        end
      end
      StShift: begin
        cnt_d = cnt_q + 1'b1;
        // Falling spi_clk: advance MOSI and sample MISO on the same edge.
        if (cnt_q == HalfLast) begin
          sclk_d = 1'b0;
          if (bit_q != BitLast) begin
            mosi_d = sh_q[1];
            sh_d   = sh_q >> 1;
          end
          if (rd_en_q) rx_d = {spi_miso, rx_q[WORD_WIDTH-1:1]};
        end
        if (cnt_q == PeriodLast) begin
          cnt_d = '0;
          if (bit_q == BitLast) begin
            state_d = StHold;
          end else begin
            bit_d  = bit_q + 1'b1;
            sclk_d = 1'b1;
          end
        end
      end
      StHold: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HalfLast) begin
          state_d = StGap;
          cnt_d   = '0;
          le_d    = 1'b1;
          mosi_d  = 1'b0;
          if (rd_en_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = rx_q;
            rd_index_d = idx_q;
          end
        end
      end
      StGap: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == GapLast) begin
          cnt_d = '0;
          if (idx_q == WordLast) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = StSetup;
            idx_d   = next_idx;
            sh_d    = word_arr[next_idx];
            mosi_d  = word_arr[next_idx][0];
            rd_en_d = read_mask[next_idx];
            le_d    = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      idx_q      <= '0;
      sh_q       <= '0;
      rx_q       <= '0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_index_q <= '0;
      sclk_q     <= 1'b0;
      le_q       <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
      rx_q       <= rx_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_index_q <= rd_index_d;
      sclk_q     <= sclk_d;
      le_q       <= le_d;
      mosi_q     <= mosi_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_index = rd_index_q;
  assign spi_clk  = sclk_q;
  assign spi_le   = le_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Bench for spi_reg_sequencer: an SPI-device monitor decodes each LE frame and checks words,
// framing, timing and readback against the programmed image.
module tb_spi_reg_sequencer;

  localparam int N   = 6;
  localparam int W   = 32;
  localparam int H   = 2;
  localparam int G   = 8;
  localparam int PER = 2 * H * (W + 1) + G;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [N*W-1:0] words = '0;
  logic [N-1:0] read_mask = '0;
  logic         busy, done, rd_valid, spi_clk, spi_le, spi_mosi;
  logic         spi_miso = 1'b0;
  logic [W-1:0] rd_data;
  logic [2:0]   rd_index;

  logic       start1 = 1'b0;
  logic [7:0] words1 = '0;
  logic       read_mask1 = 1'b0;
  logic       busy1, done1, rd_valid1, spi_clk1, spi_le1, spi_mosi1;
  logic [7:0] rd_data1;
  logic       rd_index1;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] pat [N];

  typedef struct {
    logic [N*W-1:0] w;
    logic [N-1:0]   m;
    int             mode;     // 0 plain, 1 start pulse mid-word 2, 2 start held through done
    int             abort_t;  // nonzero: reset asserted at this cycle
    bit             a5;
  } vec_t;

  vec_t tbl [8];

  spi_reg_sequencer u_dut (
    .clk(clk), .reset(reset), .start(start), .words(words), .read_mask(read_mask),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid), .rd_index(rd_index),
    .spi_clk(spi_clk), .spi_le(spi_le), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  spi_reg_sequencer #(
    .NUM_WORDS(1), .WORD_WIDTH(8), .CLK_DIV(1), .GAP_CYCLES(1)
  ) u_small (
    .clk(clk), .reset(reset), .start(start1), .words(words1), .read_mask(read_mask1),
    .busy(busy1), .done(done1), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .rd_index(rd_index1), .spi_clk(spi_clk1), .spi_le(spi_le1), .spi_mosi(spi_mosi1),
    .spi_miso(1'b0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic run_seq(input vec_t v);
    int t, wc, bits, le_len, first_rise, stray, glitch;
    logic [W-1:0] rxw;
    logic psclk, ple, pmosi;
    bit fin, aborted;
    for (int k = 0; k < N; k++) pat[k] = $urandom;
    if (v.a5) pat[3] = 32'hA5A5_0F0F;
    words = v.w;
    read_mask = v.m;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    if (v.mode != 2) start = 1'b0;
    chk("busy_rise", {63'd0, busy}, 64'd1);
    chk("le_fall", {63'd0, spi_le}, 64'd0);
    t = 0; wc = 0; bits = 0; le_len = 1; first_rise = -1; stray = 0; glitch = 0;
    rxw = '0; fin = 0; aborted = 0;
    psclk = spi_clk; ple = spi_le; pmosi = spi_mosi;
    while (!fin) begin
      @(negedge clk);
      t++;
      if (v.mode == 1) start = (t == 2 * PER + 50);
      if (v.abort_t != 0 && t == v.abort_t) begin
        reset = 1'b1;
        @(negedge clk);
        chk("rst_le", {63'd0, spi_le}, 64'd1);
        chk("rst_sclk", {63'd0, spi_clk}, 64'd0);
        chk("rst_mosi", {63'd0, spi_mosi}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_rdv", {63'd0, rd_valid}, 64'd0);
        chk("rst_rdata", {32'd0, rd_data}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_done", {63'd0, done}, 64'd0);
        fin = 1; aborted = 1;
      end else begin
        if (spi_mosi !== pmosi && spi_clk && !spi_le) glitch++;
        if (!spi_le) le_len++;
        if (spi_clk && !psclk) begin
          if (first_rise < 0) first_rise = t;
          if (bits < W && wc < N) begin
            rxw[bits] = spi_mosi;
            spi_miso = pat[wc][bits];
          end
          bits++;
        end
        if (spi_le && !ple) begin
          chk("word", {32'd0, rxw}, {32'd0, v.w[wc*W +: W]});
          chk("le_len", le_len, 2 * H * (W + 1));
          chk("bits", bits, W);
          chk("rd_valid", {63'd0, rd_valid}, {63'd0, v.m[wc]});
          if (v.m[wc]) begin
            chk("rd_data", {32'd0, rd_data}, {32'd0, pat[wc]});
            chk("rd_index", {61'd0, rd_index}, wc);
          end
          wc++; bits = 0; le_len = 0;
        end else if (rd_valid) begin
          stray++;
        end
        if (done) begin
          chk("done_t", t, N * PER);
          chk("words_sent", wc, N);
          chk("busy_fall", {63'd0, busy}, 64'd0);
          fin = 1;
        end else if (t > N * PER + 20) begin
          n_vec++; n_err++;
          $display("FAIL done_timeout: got no done by cycle %0d, expected at %0d", t, N * PER);
          fin = 1;
        end
      end
      psclk = spi_clk; ple = spi_le; pmosi = spi_mosi;
    end
    chk("first_rise", first_rise, H);
    chk("stray_rdv", stray, 0);
    chk("mosi_glitch", glitch, 0);
    if (!aborted) begin
      @(negedge clk);
      if (v.mode == 2) begin
        chk("restart_busy", {63'd0, busy}, 64'd1);
        chk("restart_le", {63'd0, spi_le}, 64'd0);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end else begin
        chk("done_pulse", {63'd0, done}, 64'd0);
      end
    end
  endtask

  task automatic run_small(input logic [7:0] b);
    int t, toggles, first, last, nb;
    logic [7:0] rx;
    logic ps;
    bit fin;
    words1 = b;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("s_busy", {63'd0, busy1}, 64'd1);
    t = 0; toggles = 0; first = -1; last = -1; nb = 0; rx = '0; fin = 0;
    ps = spi_clk1;
    while (!fin) begin
      @(negedge clk);
      t++;
      if (spi_clk1 !== ps) begin
        toggles++;
        if (first < 0) first = t;
        last = t;
      end
      if (spi_clk1 && !ps && nb < 8) begin
        rx[nb] = spi_mosi1;
        nb++;
      end
      if (done1) begin
        chk("s_done_t", t, 19);
        fin = 1;
      end else if (t > 40) begin
        n_vec++; n_err++;
        $display("FAIL s_timeout: got no done by cycle %0d, expected at 19", t);
        fin = 1;
      end
      ps = spi_clk1;
    end
    chk("s_mosi_seq", {56'd0, rx}, {56'd0, b});
    chk("s_toggles", toggles, 16);
    chk("s_first", first, 1);
    chk("s_last", last, 16);
  endtask

  initial begin
    logic [N*W-1:0] tp;
    tp = {32'h55D0_0080, 32'h8383_E001, 32'h0000_0000, 32'h6100_3BF2, 32'h6000_3BF2,
          32'h6100_3BF2};
    tbl[0] = '{tp, 6'b000000, 0, 0, 1'b0};
    tbl[1] = '{tp, 6'b001000, 0, 0, 1'b1};
    tbl[2] = '{{$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
               6'($urandom), 1, 0, 1'b0};
    tbl[3] = '{{$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
               6'b111111, 2, 0, 1'b0};
    tbl[4] = '{tp, 6'b000011, 0, PER + H + 2 * H * 17 + 1, 1'b0};
    tbl[5] = '{tp, 6'($urandom), 0, 0, 1'b0};
    tbl[6] = '{{$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
               6'($urandom), 0, 0, 1'b0};
    tbl[7] = '{{$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
               6'($urandom), 0, 0, 1'b0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_rdv", {63'd0, rd_valid}, 64'd0);
    chk("reset_rdata", {32'd0, rd_data}, 64'd0);
    chk("reset_rdidx", {61'd0, rd_index}, 64'd0);
    chk("reset_sclk", {63'd0, spi_clk}, 64'd0);
    chk("reset_le", {63'd0, spi_le}, 64'd1);
    chk("reset_mosi", {63'd0, spi_mosi}, 64'd0);
    chk("reset_le_small", {63'd0, spi_le1}, 64'd1);

    for (int i = 0; i < 8; i++) run_seq(tbl[i]);

    run_small(8'h81);
    run_small(8'($urandom));
    run_small(8'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_reg_sequencer.md
# spi_reg_sequencer

- Parametrised SPI register-programming sequencer for clock/PLL chips (CDCE62002 family and similar LE-framed serial parts).
- On `start`, shifts a configurable list of words out over a 3-wire + MISO interface, each word framed by LE low, with a programmable inter-word gap.
- Words flagged in `read_mask` also capture MISO, so register readback and EEPROM verification happen in the same pass.
- Sits between board-level init control and the PLL pins; generalises the fixed-image programmer in word count, width, SPI rate and gap.

## Interface

Parameters:
- `NUM_WORDS`, 6: number of words per sequence (≥1).
- `WORD_WIDTH`, 32: bits per word (≥2).
- `CLK_DIV`, 2: `spi_clk` half-period in `clk` cycles (≥1). H = `CLK_DIV`.
- `GAP_CYCLES`, 8: `clk` cycles LE held high between words (≥1).
- `IDX_W`, max(1, clog2(`NUM_WORDS`)): width of word index.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin sequence; honoured only when `busy`=0.
- `words` in `NUM_WORDS*WORD_WIDTH`: word k at bits [k*W +: W]; word 0 sent first.
- `read_mask` in `NUM_WORDS`: bit k=1 captures MISO during word k.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle pulse at end of sequence.
- `rd_data` out `WORD_WIDTH`: last captured readback word.
- `rd_valid` out 1: one-cycle pulse when `rd_data` updates.
- `rd_index` out `IDX_W`: word index of `rd_data`.
- `spi_clk` out 1: serial clock, idle low.
- `spi_le` out 1: latch enable, idle high, low during a word.
- `spi_mosi` out 1: serial data, LSB first.
- `spi_miso` in 1: serial data from device.

## Operation

- States:
  - IDLE → SETUP on `start`.
  - SETUP (H cycles) → SHIFT.
  - SHIFT (2H·`WORD_WIDTH` cycles) → HOLD.
  - HOLD (H cycles) → GAP.
  - GAP (`GAP_CYCLES`) → SETUP for the next word, or IDLE after word `NUM_WORDS`-1.
- SETUP: the current word is latched from `words` at SETUP entry. `spi_le`=0, `spi_mosi`=bit 0, `spi_clk`=0.
- SHIFT, per bit i:
  - High phase: `spi_clk`=1 for H cycles; the device samples on this rising edge.
  - Falling edge: `spi_clk`→0, and `spi_mosi`→bit i+1 (it holds bit W-1 after the last bit).
  - MISO: if the word's read bit is set, `spi_miso` is sampled on the clk edge that drives `spi_clk` low and shifted in LSB first.
- HOLD: `spi_clk`=0, `spi_le`=0. On exit, `spi_le`→1.
- Readback: for read-flagged words, `rd_data`/`rd_index` update and `rd_valid` pulses on the same edge where `spi_le` rises.
- GAP: `spi_le`=1, `spi_clk`=0, `spi_mosi`=0.
- End of sequence: the IDLE-entry edge sets `busy`=0 and `done`=1 for one cycle.
- Start acceptance:
  - `start` is accepted in any IDLE cycle, including the `done` cycle.
  - `start` while `busy`=1 is ignored (not queued).
- Input stability: `words` and `read_mask` must be stable from `start` until `done`. The sampled value is the one present at each SETUP entry.

## Timing

- Reset values: `busy`=0, `done`=0, `rd_valid`=0, `rd_data`=0, `rd_index`=0, `spi_clk`=0, `spi_le`=1, `spi_mosi`=0.
- `reset` mid-sequence: all outputs return to reset values on the next edge. The partial word is abandoned, with no `done` and no `rd_valid`.
- `start` sampled at edge T: `busy`=1 and `spi_le`=0 from T+1. First `spi_clk` rise at T+1+H.
- Per word: 2H(`WORD_WIDTH`+1)+`GAP_CYCLES` clk cycles. Defaults: 140 cycles/word, 840 cycles per sequence.
- `done` asserts exactly `NUM_WORDS`·(2H(W+1)+GAP) cycles after the `busy` rise edge.
- `spi_mosi` changes only while `spi_clk`=0 or LE=1. Setup and hold to the rising `spi_clk` are ≥H cycles each.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- Defaults, `words` = {0x55D00080, 0x8383E001, 0x00000000, 0x61003BF2, 0x60003BF2, 0x61003BF2} (word 0 = 0x61003BF2 in LSBs), `read_mask`=0 → monitor decodes 6 LSB-first words in order; LE low for exactly 2H·33=132 cycles each; `done` at cycle 840; `rd_valid` never asserts.
- `read_mask`=6'b001000, MISO model returns 0xA5A5_0F0F LSB first during word 3 → one `rd_valid` pulse with `rd_data`=0xA5A50F0F, `rd_index`=3, coincident with LE rise of word 3.
- `CLK_DIV`=1, `GAP_CYCLES`=1, `NUM_WORDS`=1, `WORD_WIDTH`=8, word 0x81 → `spi_clk` toggles every cycle; MOSI sequence 1,0,0,0,0,0,0,1; `done` 19 cycles after `busy` rise.
- `start` pulsed mid-word 2 → ignored, exactly 6 words sent. `start` held high through the `done` cycle → second sequence begins with `busy` rising the next cycle.
- `reset` asserted at bit 17 of word 1 → next edge: `spi_le`=1, `spi_clk`=0, `busy`=0, no `done`. A subsequent `start` sends a full, correct sequence from word 0.
